sfr_access_ctrl: RTL and testbench
==================================

// Module: sfr_access_ctrl
// PURPOSE
// Sequences all accesses to the SFR bank (8051 direct space 0x80-0xFF). Arbitrates a CPU
// port and a hardware-flag port, decodes byte/bit addresses to one-hot SFR enables,
// times around the SFRs' registered outputs, and makes byte/bit read-modify-write atomic.
// PARAMETERS
// NSFR     8         number of SFR instances on the shared bus
// SFR_MAP  see pkg   8*NSFR-bit vector; byte address of SFR i in bits [8i+7:8i]
// PORTS
// clk          in   1      single clock; all logic on posedge
// reset        in   1      synchronous, active-high
// cpu_req      in   1      CPU request; held until cpu_ack
// cpu_we       in   1      1 write, 0 read
// cpu_bit      in   1      1 bit access (addr = bit address), 0 byte access
// cpu_op       in   2      00 plain, 01 AND, 10 OR, 11 XOR (RMW when cpu_we=1, op!=00)
// cpu_addr     in   8      direct byte address or bit address
// cpu_wdata    in   8      byte write data / RMW operand
// cpu_wbit     in   1      bit write data / RMW operand
// cpu_ack      out  1      one-cycle completion pulse
// cpu_err      out  1      valid with cpu_ack: address unmapped
// cpu_rdata    out  8      valid with cpu_ack (byte read/RMW: old value)
// cpu_rbit     out  1      valid with cpu_ack (bit read/RMW: old bit)
// hw_req       in   1      flag-set/clear request (bit write only); held until hw_ack
// hw_baddr     in   8      bit address
// hw_bval      in   1      bit value
// hw_ack       out  1      one-cycle completion pulse
// sfr_en       out  NSFR   one-hot write enable
// sfr_oe       out  NSFR   one-hot output enable
// sfr_Bb       out  1      1 byte, 0 bit
// sfr_position out  8      one-hot bit position (0 for byte)
// sfr_din      out  8      byte data to SFRs
// sfr_bin      out  1      bit data to SFRs
// sfr_dout     in   8      shared (tri-state resolved) byte bus from SFRs
// sfr_bout     in   1      shared bit bus from SFRs
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; latched request and RR pointer cleared (CPU first).
// - Decode: byte -> match cpu_addr against SFR_MAP; bit -> base {addr[7:3],3'b000},
//   position = 1<<addr[2:0]. No match -> miss. Addresses <0x80 are misses.
// - Arbitration in IDLE only; both pending -> round-robin, pointer flips after each grant.
//   Granted request latched; ungranted requester keeps waiting. Access is atomic.
// - FSM: IDLE, RD, CAP, WR, ACK. Edge k accepts request (k = grant edge).
//   miss:          IDLE->ACK; ack+err at k+1 cycle, no en/oe ever asserted.
//   read:          RD (oe=1) -> CAP (oe=0, sample bus at end) -> ACK: ack in cycle k+3.
//   write/bit-wr:  WR (en=1, Bb, din/bin, position) -> ACK: ack in cycle k+2.
//   RMW:           RD -> CAP -> WR (din = old op wdata; bin = oldbit op wbit) -> ACK: k+4.
// - Bit writes are never RMW'd here; the SFR merges via position/bin.
// - en and oe never asserted together; at most one bit of each set; held for exactly 1 cycle.
// - ACK: pulse cpu_ack or hw_ack one cycle, rdata/rbit/err held stable that cycle, then IDLE.
//   A still-high req in ACK is not re-accepted until IDLE (one idle cycle minimum).
// - hw port: treated as bit write, cpu_err never set by it; hw miss acks silently.
// - Reset mid-operation: abort to IDLE next edge, no ack, no en; partial RMW discarded.
// STRUCTURE
// - Shared header sfr_map pkg: SFR address constants (P0 80,SP 81,DPL 82,DPH 83,TCON 88,
//   TMOD 89,PSW D0,ACC E0,B F0), default SFR_MAP, op codes, FSM state encodings.
// - Sub-module sfr_addr_decode: combinational addr,bit -> sel one-hot, hit, position.
// TESTING
// - Byte write 0x5A to ACC(E0) -> sfr_en[ACC] one cycle, ack at k+2; read back 0x5A at k+3.
// - Bit write 1 to bit D7 (PSW.7) with PSW=00 -> PSW=80; bit read D7 -> rbit=1.
// - RMW XOR 0xFF on B=0x0F -> B=F0, rdata=0F, ack at k+4; bit XOR 1 on E0 toggles ACC.0.
// - cpu_req and hw_req same cycle twice -> grants CPU then hw then CPU; no en/oe overlap.
// - Read 0x84 (unmapped) -> ack+err at k+1, rdata=00, sfr_en/oe stay 0.
// - reset asserted in CAP of RMW -> no WR, no ack, target SFR unchanged, IDLE next cycle.

Source files
------------

// File: rtl/sfr_access_ctrl_pkg.sv
// Shared definitions for the SFR access sequencer.
// Contents: SFR byte addresses, the default SFR map (slot i in bits [8i+7:8i]),
// RMW op codes, FSM state encoding and the RMW combine helpers.
package sfr_access_ctrl_pkg;

  localparam int NSFR_DEFAULT = 8;

  localparam logic [7:0] ADDR_P0   = 8'h80;
  localparam logic [7:0] ADDR_SP   = 8'h81;
  localparam logic [7:0] ADDR_DPL  = 8'h82;
  localparam logic [7:0] ADDR_DPH  = 8'h83;
  localparam logic [7:0] ADDR_TCON = 8'h88;
  localparam logic [7:0] ADDR_TMOD = 8'h89;
  localparam logic [7:0] ADDR_PSW  = 8'hD0;
  localparam logic [7:0] ADDR_ACC  = 8'hE0;
  localparam logic [7:0] ADDR_B    = 8'hF0;

  // Slot 0 is in the low byte. TMOD has a constant but no slot in the
  // eight-instance default bank.
  localparam logic [8*NSFR_DEFAULT-1:0] SFR_MAP_DEFAULT = {
    ADDR_B, ADDR_ACC, ADDR_PSW, ADDR_TCON, ADDR_DPH, ADDR_DPL, ADDR_SP, ADDR_P0
  };

  localparam logic [1:0] OP_PLAIN = 2'b00;
  localparam logic [1:0] OP_AND   = 2'b01;
  localparam logic [1:0] OP_OR    = 2'b10;
  localparam logic [1:0] OP_XOR   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_ACK  = 3'd4
  } state_t;

  function automatic logic [7:0] apply_op(input logic [1:0] op,
                                          input logic [7:0] old_val,
                                          input logic [7:0] operand);
    case (op)
      OP_AND:  apply_op = old_val & operand;
      OP_OR:   apply_op = old_val | operand;
      OP_XOR:  apply_op = old_val ^ operand;
      default: apply_op = operand;
    endcase
  endfunction

  function automatic logic apply_op_bit(input logic [1:0] op,
                                        input logic old_bit,
                                        input logic operand);
    case (op)
      OP_AND:  apply_op_bit = old_bit & operand;
      OP_OR:   apply_op_bit = old_bit | operand;
      OP_XOR:  apply_op_bit = old_bit ^ operand;
      default: apply_op_bit = operand;
    endcase
  endfunction

endpackage

// File: rtl/sfr_access_ctrl_addr_decode.sv
// Combinational address decoder for the SFR bank.
// Ports: addr (byte or bit address), bit_mode (1 = bit address),
//        sel (one-hot SFR select), hit (some SFR matched),
//        position (one-hot bit position, 0 for byte accesses).
module sfr_access_ctrl_addr_decode
  import sfr_access_ctrl_pkg::*;
#(
  parameter int                NSFR    = NSFR_DEFAULT,
  parameter logic [8*NSFR-1:0] SFR_MAP = SFR_MAP_DEFAULT
) (
  input  logic [7:0]      addr,
  input  logic            bit_mode,
  output logic [NSFR-1:0] sel,
  output logic            hit,
  output logic [7:0]      position
);

  logic [7:0] base;

  // Bit addresses 0x80-0xFF name bit addr[2:0] of the SFR at {addr[7:3],000}.
  assign base     = bit_mode ? {addr[7:3], 3'b000} : addr;
  assign position = bit_mode ? (8'd1 << addr[2:0]) : 8'd0;

  genvar gi;
  generate
    for (gi = 0; gi < NSFR; gi++) begin : g_match
      // Anything below 0x80 is internal RAM / RAM bit space, never an SFR.
      assign sel[gi] = addr[7] && (SFR_MAP[8*gi +: 8] == base);
    end
  endgenerate

  assign hit = |sel;

endmodule

// File: rtl/sfr_access_ctrl.sv
// SFR bank access sequencer: arbitrates a CPU port and a hardware flag port,
// decodes addresses to one-hot SFR enables and sequences read, write and
// atomic read-modify-write accesses around the SFRs' registered outputs.
// Ports: clk/reset; CPU request port (cpu_req/we/bit/op/addr/wdata/wbit ->
//        cpu_ack/err/rdata/rbit); hw flag port (hw_req/baddr/bval -> hw_ack);
//        SFR bus (sfr_en, sfr_oe, sfr_Bb, sfr_position, sfr_din, sfr_bin out;
//        sfr_dout, sfr_bout in).
module sfr_access_ctrl
  import sfr_access_ctrl_pkg::*;
#(
  parameter int                NSFR    = NSFR_DEFAULT,
  parameter logic [8*NSFR-1:0] SFR_MAP = SFR_MAP_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic            cpu_bit,
  input  logic [1:0]      cpu_op,
  input  logic [7:0]      cpu_addr,
  input  logic [7:0]      cpu_wdata,
  input  logic            cpu_wbit,
  output logic            cpu_ack,
  output logic            cpu_err,
  output logic [7:0]      cpu_rdata,
  output logic            cpu_rbit,
  input  logic            hw_req,
  input  logic [7:0]      hw_baddr,
  input  logic            hw_bval,
  output logic            hw_ack,
  output logic [NSFR-1:0] sfr_en,
  output logic [NSFR-1:0] sfr_oe,
  output logic            sfr_Bb,
  output logic [7:0]      sfr_position,
  output logic [7:0]      sfr_din,
  output logic            sfr_bin,
  input  logic [7:0]      sfr_dout,
  input  logic            sfr_bout
);

  state_t state_reg, state_next;

  logic            rr_hw_reg;   // 1: hw port wins the next contested grant
  logic            grant_cpu, grant_hw, take;
  logic [7:0]      dec_addr;
  logic            dec_bit;
  logic [NSFR-1:0] dec_sel;
  logic            dec_hit;
  logic [7:0]      dec_pos;
  logic            req_we, req_rmw;

  logic            lat_hw_reg, lat_bit_reg, lat_rmw_reg, lat_hit_reg, lat_wbit_reg;
  logic [1:0]      lat_op_reg;
  logic [7:0]      lat_wdata_reg, lat_pos_reg;
  logic [NSFR-1:0] lat_sel_reg;
  logic [7:0]      rdata_reg;
  logic            rbit_reg;

  assign grant_cpu = cpu_req && (!hw_req || !rr_hw_reg);
  assign grant_hw  = hw_req && (!cpu_req || rr_hw_reg);
  assign take      = (state_reg == ST_IDLE) && (cpu_req || hw_req);

  // One decoder serves whichever port wins; hw requests are always bit writes.
  assign dec_addr = grant_hw ? hw_baddr : cpu_addr;
  assign dec_bit  = grant_hw ? 1'b1 : cpu_bit;
  assign req_we   = grant_hw || cpu_we;
  assign req_rmw  = !grant_hw && cpu_we && (cpu_op != OP_PLAIN);

  sfr_access_ctrl_addr_decode #(
    .NSFR    (NSFR),
    .SFR_MAP (SFR_MAP)
  ) u_decode (
    .addr     (dec_addr),
    .bit_mode (dec_bit),
    .sel      (dec_sel),
    .hit      (dec_hit),
    .position (dec_pos)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request latch, round-robin pointer and read capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_hw_reg     <= 1'b0;
      lat_hw_reg    <= 1'b0;
      lat_bit_reg   <= 1'b0;
      lat_rmw_reg   <= 1'b0;
      lat_hit_reg   <= 1'b0;
      lat_wbit_reg  <= 1'b0;
      lat_op_reg    <= OP_PLAIN;
      lat_wdata_reg <= 8'h00;
      lat_pos_reg   <= 8'h00;
      lat_sel_reg   <= '0;
      rdata_reg     <= 8'h00;
      rbit_reg      <= 1'b0;
    end else begin
      if (take) begin
        rr_hw_reg     <= grant_cpu;
        lat_hw_reg    <= grant_hw;
        lat_bit_reg   <= dec_bit;
        lat_rmw_reg   <= req_rmw;
        lat_hit_reg   <= dec_hit;
        lat_wbit_reg  <= grant_hw ? hw_bval : cpu_wbit;
        lat_op_reg    <= grant_hw ? OP_PLAIN : cpu_op;
        lat_wdata_reg <= grant_hw ? 8'h00 : cpu_wdata;
        lat_pos_reg   <= dec_pos;
        lat_sel_reg   <= dec_sel;
        // Cleared here so misses and writes return zero data.
        rdata_reg     <= 8'h00;
        rbit_reg      <= 1'b0;
      end
      // The SFR registered its output on the RD->CAP edge; the bus is valid now.
      if (state_reg == ST_CAP) begin
        rdata_reg <= lat_bit_reg ? 8'h00 : sfr_dout;
        rbit_reg  <= lat_bit_reg ? sfr_bout : 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (take) begin
          if (!dec_hit)                 state_next = ST_ACK;
          else if (req_we && !req_rmw)  state_next = ST_WR;
          else                          state_next = ST_RD;
        end
      end
      ST_RD:   state_next = ST_CAP;
      ST_CAP:  state_next = lat_rmw_reg ? ST_WR : ST_ACK;
      ST_WR:   state_next = ST_ACK;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sfr_en       = '0;
    sfr_oe       = '0;
    sfr_Bb       = 1'b0;
    sfr_position = 8'h00;
    sfr_din      = 8'h00;
    sfr_bin      = 1'b0;
    cpu_ack      = 1'b0;
    cpu_err      = 1'b0;
    cpu_rdata    = 8'h00;
    cpu_rbit     = 1'b0;
    hw_ack       = 1'b0;
    case (state_reg)
      ST_RD: begin
        sfr_oe       = lat_sel_reg;
        sfr_Bb       = !lat_bit_reg;
        sfr_position = lat_pos_reg;
      end
      ST_CAP: begin
        sfr_Bb       = !lat_bit_reg;
        sfr_position = lat_pos_reg;
      end
      ST_WR: begin
        sfr_en       = lat_sel_reg;
        sfr_Bb       = !lat_bit_reg;
        sfr_position = lat_pos_reg;
        // lat_op_reg is PLAIN for non-RMW writes, so the helpers pass the operand.
        if (lat_bit_reg) begin
          sfr_bin = apply_op_bit(lat_op_reg, rbit_reg, lat_wbit_reg);
        end else begin
          sfr_din = apply_op(lat_op_reg, rdata_reg, lat_wdata_reg);
        end
      end
      ST_ACK: begin
        if (lat_hw_reg) begin
          hw_ack = 1'b1;
        end else begin
          cpu_ack   = 1'b1;
          cpu_err   = !lat_hit_reg;
          cpu_rdata = rdata_reg;
          cpu_rbit  = rbit_reg;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sfr_access_ctrl.sv
`timescale 1ns/1ps
module tb_sfr_access_ctrl;
  import sfr_access_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0, cpu_bit = 1'b0, cpu_wbit = 1'b0;
  logic [1:0] cpu_op = 2'b00;
  logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
  logic       cpu_ack, cpu_err, cpu_rbit;
  logic [7:0] cpu_rdata;
  logic       hw_req = 1'b0, hw_bval = 1'b0;
  logic [7:0] hw_baddr = 8'h00;
  logic       hw_ack;
  logic [7:0] sfr_en, sfr_oe, sfr_position, sfr_din, sfr_dout;
  logic       sfr_Bb, sfr_bin, sfr_bout;

  always #5 clk = ~clk;

  sfr_access_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bit(cpu_bit), .cpu_op(cpu_op),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wbit(cpu_wbit),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .cpu_rbit(cpu_rbit),
    .hw_req(hw_req), .hw_baddr(hw_baddr), .hw_bval(hw_bval), .hw_ack(hw_ack),
    .sfr_en(sfr_en), .sfr_oe(sfr_oe), .sfr_Bb(sfr_Bb), .sfr_position(sfr_position),
    .sfr_din(sfr_din), .sfr_bin(sfr_bin), .sfr_dout(sfr_dout), .sfr_bout(sfr_bout)
  );

  // ---------------- SFR bank model (registered outputs) ----------------
  logic [7:0] sfr_mem [8];
  logic [7:0] bus_d;
  logic       bus_b;
  logic       sfr_init = 1'b1;
  assign sfr_dout = bus_d;
  assign sfr_bout = bus_b;

  always @(posedge clk) begin
    bus_d <= 8'h00;
    bus_b <= 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (sfr_init) begin
        sfr_mem[i] <= 8'h00;
      end else if (sfr_en[i]) begin
        if (sfr_Bb) sfr_mem[i] <= sfr_din;
        else        sfr_mem[i] <= (sfr_mem[i] & ~sfr_position) | (sfr_bin ? sfr_position : 8'h00);
      end
      if (sfr_oe[i]) begin
        bus_d <= sfr_mem[i];
        bus_b <= |(sfr_mem[i] & sfr_position);
      end
    end
  end

  // ---------------- bus protocol monitor ----------------
  int   en_cycles = 0, oe_cycles = 0, cpu_ack_cnt = 0, viol = 0;
  logic prev_en = 1'b0, prev_oe = 1'b0;
  always @(negedge clk) begin
    if ((sfr_en & sfr_oe) != 8'h00 || !$onehot0(sfr_en) || !$onehot0(sfr_oe) ||
        (cpu_ack && hw_ack) || (prev_en && sfr_en != 8'h00) || (prev_oe && sfr_oe != 8'h00))
      viol++;
    if (sfr_en != 8'h00) en_cycles++;
    if (sfr_oe != 8'h00) oe_cycles++;
    if (cpu_ack) cpu_ack_cnt++;
    prev_en = (sfr_en != 8'h00);
    prev_oe = (sfr_oe != 8'h00);
  end

  // ---------------- reference model ----------------
  localparam logic [7:0] MAP_ADDRS [8] = '{ADDR_P0, ADDR_SP, ADDR_DPL, ADDR_DPH,
                                           ADDR_TCON, ADDR_PSW, ADDR_ACC, ADDR_B};
  logic [7:0] ref_mem [8];
  int vectors = 0, miscompares = 0;

  function automatic int lookup(input logic bitacc, input logic [7:0] a);
    logic [7:0] base;
    lookup = -1;
    base = bitacc ? (a & 8'hF8) : a;
    if (a >= 8'h80)
      for (int i = 0; i < 8; i++) if (MAP_ADDRS[i] == base) lookup = i;
  endfunction

  function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (op == 2'd1) return a & b;
    if (op == 2'd2) return a | b;
    if (op == 2'd3) return a ^ b;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_txn(input string tag, input logic we, input logic bt, input logic [1:0] op,
                         input logic [7:0] addr, input logic [7:0] wdata, input logic wb);
    int idx, pos, lat, en0, oe0, exp_lat;
    logic got, rmw, a_err, a_rbit, old_b, new_b;
    logic [7:0] a_rdata, old_v;
    idx = lookup(bt, addr);
    pos = int'(addr % 8);
    rmw = we && (op != 2'b00);
    en0 = en_cycles; oe0 = oe_cycles;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_bit = bt; cpu_op = op;
    cpu_addr = addr; cpu_wdata = wdata; cpu_wbit = wb;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (cpu_ack) got = 1'b1;
    end
    a_err = cpu_err; a_rdata = cpu_rdata; a_rbit = cpu_rbit;
    check({tag, ".hw_ack_quiet"}, 32'(hw_ack), 0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check({tag, ".ack_done"}, 32'(got), 1);
    check({tag, ".ack_pulse"}, 32'(cpu_ack), 0);
    if (idx < 0) begin
      exp_lat = 1;
      check({tag, ".err"}, 32'(a_err), 1);
      check({tag, ".rdata"}, 32'(a_rdata), 0);
      check({tag, ".en_cycles"}, 32'(en_cycles - en0), 0);
      check({tag, ".oe_cycles"}, 32'(oe_cycles - oe0), 0);
    end else begin
      check({tag, ".err"}, 32'(a_err), 0);
      old_v = ref_mem[idx];
      old_b = old_v[pos];
      exp_lat = !we ? 3 : (rmw ? 4 : 2);
      if (!we || rmw) begin
        if (bt) check({tag, ".rbit"}, 32'(a_rbit), 32'(old_b));
        else    check({tag, ".rdata"}, 32'(a_rdata), 32'(old_v));
      end
      if (we) begin
        if (bt) begin
          new_b = rmw ? ref_op(op, {7'b0, old_b}, {7'b0, wb}) != 8'h00 : wb;
          ref_mem[idx][pos] = new_b;
        end else begin
          ref_mem[idx] = ref_op(op, old_v, wdata);
        end
      end
      check({tag, ".en_cycles"}, 32'(en_cycles - en0), we ? 1 : 0);
      check({tag, ".oe_cycles"}, 32'(oe_cycles - oe0), (!we || rmw) ? 1 : 0);
      check({tag, ".sfr_value"}, 32'(sfr_mem[idx]), 32'(ref_mem[idx]));
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    $display("cpu %s we=%0d bit=%0d op=%0d addr=%02h wdata=%02h wbit=%0d -> err=%0d rdata=%02h rbit=%0d lat=%0d",
             tag, we, bt, op, addr, wdata, wb, a_err, a_rdata, a_rbit, lat);
  endtask

  task automatic hw_txn(input string tag, input logic [7:0] addr, input logic val);
    int idx, lat, en0;
    logic got;
    idx = lookup(1'b1, addr);
    en0 = en_cycles;
    @(negedge clk);
    hw_req = 1'b1; hw_baddr = addr; hw_bval = val;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (hw_ack) got = 1'b1;
    end
    check({tag, ".cpu_quiet"}, 32'({cpu_ack, cpu_err}), 0);
    hw_req = 1'b0;
    @(posedge clk); #1;
    check({tag, ".ack_done"}, 32'(got), 1);
    check({tag, ".latency"}, 32'(lat), idx < 0 ? 1 : 2);
    check({tag, ".en_cycles"}, 32'(en_cycles - en0), idx < 0 ? 0 : 1);
    if (idx >= 0) begin
      ref_mem[idx][int'(addr % 8)] = val;
      check({tag, ".sfr_value"}, 32'(sfr_mem[idx]), 32'(ref_mem[idx]));
    end
    $display("hw  %s baddr=%02h val=%0d -> lat=%0d", tag, addr, val, lat);
  endtask

  // Both ports request in the same cycle: CPU writes DPL, hw writes TCON.4.
  task automatic arb_pair(input string tag, input logic exp_cpu_first);
    int n;
    logic cdone, hdone, cpu_first;
    logic [7:0] wd;
    logic hv;
    wd = 8'($urandom_range(0, 255));
    hv = 1'($urandom_range(0, 1));
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_bit = 1'b0; cpu_op = 2'b00; cpu_addr = ADDR_DPL; cpu_wdata = wd;
    hw_req = 1'b1; hw_baddr = 8'h8C; hw_bval = hv;
    n = 0; cdone = 1'b0; hdone = 1'b0; cpu_first = 1'b0;
    while (!(cdone && hdone) && n < 40) begin
      @(posedge clk); #1; n++;
      if (cpu_ack) begin cdone = 1'b1; cpu_req = 1'b0; if (!hdone) cpu_first = 1'b1; end
      if (hw_ack)  begin hdone = 1'b1; hw_req = 1'b0; end
    end
    @(posedge clk); #1;
    ref_mem[2] = wd;
    ref_mem[4][4] = hv;
    check({tag, ".both_done"}, 32'({cdone, hdone}), 3);
    check({tag, ".cpu_first"}, 32'(cpu_first), 32'(exp_cpu_first));
    check({tag, ".dpl"}, 32'(sfr_mem[2]), 32'(ref_mem[2]));
    check({tag, ".tcon"}, 32'(sfr_mem[4]), 32'(ref_mem[4]));
    $display("arb %s cpu_first=%0d cycles=%0d", tag, cpu_first, n);
  endtask

  initial begin
    int en0, ack0;
    logic [7:0] old_b;
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.outputs", 32'({cpu_ack, cpu_err, cpu_rdata, cpu_rbit, hw_ack}), 0);
    check("reset.bus", 32'({sfr_en, sfr_oe, sfr_Bb, sfr_position}), 0);
    check("reset.bus_data", 32'({sfr_din, sfr_bin}), 0);
    @(negedge clk);
    reset = 1'b0; sfr_init = 1'b0;

    // directed accesses
    cpu_txn("acc_wr",  1, 0, 2'b00, ADDR_ACC, 8'h5A, 0);
    cpu_txn("acc_rd",  0, 0, 2'b00, ADDR_ACC, 8'h00, 0);
    cpu_txn("psw7_wr", 1, 1, 2'b00, 8'hD7, 8'h00, 1);
    check("psw_is_80", 32'(sfr_mem[5]), 32'h80);
    cpu_txn("psw7_rd", 0, 1, 2'b00, 8'hD7, 8'h00, 0);
    cpu_txn("b_wr",    1, 0, 2'b00, ADDR_B, 8'h0F, 0);
    cpu_txn("b_xor",   1, 0, 2'b11, ADDR_B, 8'hFF, 0);
    check("b_is_f0", 32'(sfr_mem[7]), 32'hF0);
    cpu_txn("acc0_xor", 1, 1, 2'b11, 8'hE0, 8'h00, 1);
    check("acc_is_5b", 32'(sfr_mem[6]), 32'h5B);
    cpu_txn("sp_and",  1, 0, 2'b01, ADDR_SP, 8'h3C, 0);
    cpu_txn("dph_or",  1, 0, 2'b10, ADDR_DPH, 8'hA5, 0);
    cpu_txn("miss_84", 0, 0, 2'b00, 8'h84, 8'h00, 0);
    cpu_txn("miss_tmod", 1, 0, 2'b00, ADDR_TMOD, 8'h12, 0);
    cpu_txn("miss_low", 0, 1, 2'b00, 8'h10, 8'h00, 0);
    cpu_txn("p0_bit_or", 1, 1, 2'b10, 8'h87, 8'h00, 1);
    hw_txn("hw_tcon0", 8'h88, 1);
    hw_txn("hw_miss", 8'h40, 1);

    // reset during CAP of a byte RMW on B
    old_b = sfr_mem[7];
    en0 = en_cycles; ack0 = cpu_ack_cnt;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_bit = 1'b0; cpu_op = 2'b11; cpu_addr = ADDR_B; cpu_wdata = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid.idle_bus", 32'({sfr_en, sfr_oe, cpu_ack}), 0);
    @(negedge clk);
    reset = 1'b0; cpu_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid.no_en", 32'(en_cycles - en0), 0);
    check("rst_mid.no_ack", 32'(cpu_ack_cnt - ack0), 0);
    check("rst_mid.b_kept", 32'(sfr_mem[7]), 32'(old_b));
    $display("rst mid-RMW on B: b=%02h", sfr_mem[7]);

    // arbitration (pointer is CPU-first after reset)
    arb_pair("arb1", 1'b1);
    arb_pair("arb2", 1'b1);
    cpu_txn("arb_solo", 0, 0, 2'b00, ADDR_DPL, 8'h00, 0);
    arb_pair("arb3", 1'b0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [7:0] a;
      logic bt;
      bt = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) a = 8'($urandom_range(0, 255));
      else if (bt) a = MAP_ADDRS[$urandom_range(0, 7)] | 8'($urandom_range(0, 7));
      else a = MAP_ADDRS[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0)
        hw_txn("rnd_hw", a, 1'($urandom_range(0, 1)));
      else
        cpu_txn("rnd_cpu", 1'($urandom_range(0, 1)), bt, 2'($urandom_range(0, 3)),
                a, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    check("protocol.violations", 32'(viol), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
